// File: rtl/pet_feeder_ctrl_pkg.sv
// rtl/pet_feeder_ctrl_pkg.sv - shared option codes, FSM encoding and defaults for the pet feeder
package pet_feeder_ctrl_pkg;

  localparam logic [2:0] OPT_IDLE      = 3'd0;
  localparam logic [2:0] OPT_POUR_FOOD = 3'd1;
  localparam logic [2:0] OPT_STOP_FOOD = 3'd2;
  localparam logic [2:0] OPT_INTERVAL  = 3'd3;
  localparam logic [2:0] OPT_RESET     = 3'd4;

  localparam int DEFAULT_POUR_TICKS = 10;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_POUR     = 2'd1,
    ST_PERIODIC = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/pet_feeder_ctrl_digit_accumulator.sv
// rtl/pet_feeder_ctrl_digit_accumulator.sv - decimal keypad accumulator with edge-detected strobe
module digit_accumulator
  import pet_feeder_ctrl_pkg::*;
#(
  parameter int INTERVAL_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            keyboard_digit,
  input  logic                  digit_enable,
  input  logic                  clear,
  output logic [INTERVAL_W-1:0] sum
);

  // Four extra bits hold sum*10+9 without overflow before saturating.
  localparam int EXT_W = INTERVAL_W + 4;
  localparam logic [EXT_W-1:0] SAT_VALUE = {4'b0000, {INTERVAL_W{1'b1}}};

  logic             digit_enable_q;
  logic             digit_event;
  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] next_ext;

  assign digit_event = digit_enable & ~digit_enable_q;

  always_comb begin
    sum_ext  = {4'b0000, sum};
    next_ext = (sum_ext << 3) + (sum_ext << 1) + EXT_W'(keyboard_digit);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_enable_q <= 1'b0;
      sum            <= '0;
    end else begin
      digit_enable_q <= digit_enable;
      if (clear) begin
        sum <= '0;
      end else if (digit_event && (keyboard_digit <= DIGIT_MAX)) begin
        if (next_ext > SAT_VALUE) begin
          sum <= {INTERVAL_W{1'b1}};
        end else begin
          sum <= next_ext[INTERVAL_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pet_feeder_ctrl.sv
// rtl/pet_feeder_ctrl.sv - option FSM, pour and interval timers, and food valve gating
module pet_feeder_ctrl
  import pet_feeder_ctrl_pkg::*;
#(
  parameter int POUR_TICKS = DEFAULT_POUR_TICKS,
  parameter int INTERVAL_W = 16,
  parameter int COUNT_W    = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] keyboard_option,
  input  logic       option_enable,
  input  logic [3:0] keyboard_digit,
  input  logic       digit_enable,
  input  logic       empty_tank_sensor,
  input  logic       full_bowl_sensor,
  output logic       food_switch
);

  localparam logic [3:0]         POUR_LIMIT   = 4'(POUR_TICKS);
  localparam logic [COUNT_W-1:0] PERIOD_LIMIT = COUNT_W'(POUR_TICKS);

  feeder_state_t           state;
  logic                    option_enable_q;
  logic                    option_event;
  logic                    clear_sum;
  logic                    blocked;
  logic [3:0]              pour_count;
  logic [COUNT_W-1:0]      int_count;
  logic [INTERVAL_W-1:0]   sum;
  logic [INTERVAL_W-1:0]   interval;
  logic [COUNT_W-1:0]      interval_ext;
  logic                    pour_active;
  logic                    period_active;

  assign option_event = option_enable & ~option_enable_q;
  assign clear_sum    = option_event && (keyboard_option == OPT_RESET);
  assign blocked      = full_bowl_sensor | empty_tank_sensor;

  digit_accumulator #(
    .INTERVAL_W (INTERVAL_W)
  ) u_acc (
    .clock          (clock),
    .reset          (reset),
    .keyboard_digit (keyboard_digit),
    .digit_enable   (digit_enable),
    .clear          (clear_sum),
    .sum            (sum)
  );

  assign interval     = sum;
  assign interval_ext = COUNT_W'(interval);

  assign pour_active   = (pour_count < POUR_LIMIT);
  assign period_active = (interval != '0) && (int_count < PERIOD_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      option_enable_q <= 1'b0;
      pour_count      <= '0;
      int_count       <= '0;
    end else begin
      option_enable_q <= option_enable;
      if (option_event && (keyboard_option == OPT_POUR_FOOD)) begin
        state      <= ST_POUR;
        pour_count <= '0;
      end else if (option_event && (keyboard_option == OPT_INTERVAL)) begin
        state     <= ST_PERIODIC;
        int_count <= '0;
      end else if (option_event && ((keyboard_option == OPT_STOP_FOOD) ||
                                    (keyboard_option == OPT_RESET))) begin
        state      <= ST_IDLE;
        pour_count <= '0;
        int_count  <= '0;
      end else begin
        case (state)
          ST_POUR: begin
            // A blocked pour freezes the burst so it resumes once sensors clear.
            if (pour_active && !blocked) begin
              pour_count <= pour_count + 4'd1;
            end
          end
          ST_PERIODIC: begin
            // >= also catches a count left beyond a freshly shortened interval.
            if ((interval == '0) || (int_count >= interval_ext - COUNT_W'(1))) begin
              int_count <= '0;
            end else begin
              int_count <= int_count + COUNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign food_switch = ~full_bowl_sensor & ~empty_tank_sensor &
                       (((state == ST_POUR) & pour_active) |
                        ((state == ST_PERIODIC) & period_active));

endmodule

// File: tb/tb_pet_feeder_ctrl.sv
// tb/tb_pet_feeder_ctrl.sv - directed self-checking bench for pet_feeder_ctrl
module tb_pet_feeder_ctrl;
  import pet_feeder_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] keyboard_option = 3'd0;
  logic       option_enable = 1'b0;
  logic [3:0] keyboard_digit = 4'd0;
  logic       digit_enable = 1'b0;
  logic       empty_tank_sensor = 1'b0;
  logic       full_bowl_sensor = 1'b0;
  logic       food_switch;

  int tests = 0;
  int fails = 0;

  pet_feeder_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .keyboard_option   (keyboard_option),
    .option_enable     (option_enable),
    .keyboard_digit    (keyboard_digit),
    .digit_enable      (digit_enable),
    .empty_tank_sensor (empty_tank_sensor),
    .full_bowl_sensor  (full_bowl_sensor),
    .food_switch       (food_switch)
  );

  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      keyboard_option   = 3'($urandom);
      option_enable     = 1'($urandom);
      keyboard_digit    = 4'($urandom);
      digit_enable      = 1'($urandom);
      empty_tank_sensor = 1'($urandom);
      full_bowl_sensor  = 1'($urandom);
      sample();
      tests++;
      if (food_switch !== 1'b0) begin
        fails++;
        $display("FAIL reset_fs cycle %0d: got %b want 0", i, food_switch);
      end
      tests++;
      if (dut.sum !== 16'd0) begin
        fails++;
        $display("FAIL reset_sum cycle %0d: got %0d want 0", i, dut.sum);
      end
    end
    next_cycle();
    keyboard_option = 3'd0; option_enable = 1'b0; keyboard_digit = 4'd0;
    digit_enable = 1'b0; empty_tank_sensor = 1'b0; full_bowl_sensor = 1'b0;
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      tests++;
      if (food_switch !== 1'b0 || dut.sum !== 16'd0) begin
        fails++;
        $display("FAIL after_reset cycle %0d: fs %b sum %0d want 0/0", i, food_switch, dut.sum);
      end
      next_cycle();
    end
  endtask

  task automatic test_pour();
    for (int rep = 0; rep < 2; rep++) begin
      next_cycle();
      keyboard_option = OPT_POUR_FOOD;
      option_enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
        next_cycle();
        if (i == 2) option_enable = 1'b0;
        sample();
        tests++;
        if (food_switch !== (i < 10)) begin
          fails++;
          $display("FAIL pour rep %0d cycle %0d: got %b want %b", rep, i, food_switch, (i < 10));
        end
      end
    end
  endtask

  task automatic test_stop_mid_pour();
    next_cycle();
    keyboard_option = OPT_POUR_FOOD;
    option_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (i == 1) option_enable = 1'b0;
      if (i == 3) begin keyboard_option = OPT_STOP_FOOD; option_enable = 1'b1; end
      if (i == 4) option_enable = 1'b0;
      sample();
      tests++;
      if (food_switch !== (i < 4)) begin
        fails++;
        $display("FAIL stop_mid_pour cycle %0d: got %b want %b", i, food_switch, (i < 4));
      end
    end
  endtask

  task automatic test_async_reset();
    next_cycle();
    keyboard_option = OPT_POUR_FOOD;
    option_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 1) option_enable = 1'b0;
    end
    sample();
    tests++;
    if (food_switch !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_pre: got %b want 1", food_switch);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (food_switch !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_drop: got %b want 0", food_switch);
    end
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      tests++;
      if (food_switch !== 1'b0) begin
        fails++;
        $display("FAIL async_reset_post cycle %0d: got %b want 0", i, food_switch);
      end
      next_cycle();
    end
  endtask

  task automatic test_pour_sensor();
    logic exp_fs;
    next_cycle();
    keyboard_option = OPT_POUR_FOOD;
    option_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      if (i == 1) option_enable = 1'b0;
      full_bowl_sensor = (i >= 3 && i <= 7);
      sample();
      exp_fs = (i < 3) || (i >= 8 && i < 15);
      tests++;
      if (food_switch !== exp_fs) begin
        fails++;
        $display("FAIL pour_sensor cycle %0d: got %b want %b", i, food_switch, exp_fs);
      end
    end
    full_bowl_sensor = 1'b0;
  endtask

  task automatic test_interval();
    logic exp_fs;
    next_cycle(); keyboard_digit = 4'd6; digit_enable = 1'b1;
    next_cycle(); digit_enable = 1'b0;
    next_cycle(); keyboard_digit = 4'd4; digit_enable = 1'b1;
    next_cycle(); digit_enable = 1'b0;
    sample();
    tests++;
    if (dut.sum !== 16'd64) begin
      fails++;
      $display("FAIL interval_sum: got %0d want 64", dut.sum);
    end
    next_cycle();
    keyboard_option = OPT_INTERVAL;
    option_enable = 1'b1;
    for (int i = 0; i < 330; i++) begin
      next_cycle();
      if (i == 0) option_enable = 1'b0;
      empty_tank_sensor = (i >= 200 && i <= 265);
      sample();
      exp_fs = !(i >= 200 && i <= 265) && ((i % 64) < 10);
      tests++;
      if (food_switch !== exp_fs) begin
        fails++;
        $display("FAIL interval cycle %0d: got %b want %b", i, food_switch, exp_fs);
      end
    end
    empty_tank_sensor = 1'b0;
    next_cycle();
    keyboard_option = OPT_STOP_FOOD;
    option_enable = 1'b1;
    for (int i = 0; i < 70; i++) begin
      next_cycle();
      option_enable = 1'b0;
      sample();
      tests++;
      if (food_switch !== 1'b0) begin
        fails++;
        $display("FAIL interval_stop cycle %0d: got %b want 0", i, food_switch);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_sum [6] = '{16'd9, 16'd99, 16'd999, 16'd9999, 16'd65535, 16'd65535};
    next_cycle(); keyboard_option = OPT_RESET; option_enable = 1'b1;
    next_cycle(); option_enable = 1'b0;
    sample();
    tests++;
    if (dut.sum !== 16'd0) begin
      fails++;
      $display("FAIL reset_option_sum: got %0d want 0", dut.sum);
    end
    next_cycle(); keyboard_digit = 4'd3; digit_enable = 1'b1;
    next_cycle(); next_cycle();
    next_cycle(); digit_enable = 1'b0;
    next_cycle(); keyboard_digit = 4'd5; digit_enable = 1'b1;
    next_cycle(); digit_enable = 1'b0;
    next_cycle(); keyboard_digit = 4'd12; digit_enable = 1'b1;
    next_cycle(); digit_enable = 1'b0;
    sample();
    tests++;
    if (dut.sum !== 16'd35) begin
      fails++;
      $display("FAIL held_strobe_and_digit12: got %0d want 35", dut.sum);
    end
    next_cycle();
    keyboard_option = OPT_RESET; option_enable = 1'b1;
    keyboard_digit = 4'd7; digit_enable = 1'b1;
    next_cycle(); option_enable = 1'b0; digit_enable = 1'b0;
    sample();
    tests++;
    if (dut.sum !== 16'd0) begin
      fails++;
      $display("FAIL reset_with_digit: got %0d want 0", dut.sum);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle(); keyboard_digit = 4'd9; digit_enable = 1'b1;
      next_cycle(); digit_enable = 1'b0;
      sample();
      tests++;
      if (dut.sum !== exp_sum[k]) begin
        fails++;
        $display("FAIL saturation digit %0d: got %0d want %0d", k, dut.sum, exp_sum[k]);
      end
    end
    next_cycle(); keyboard_option = OPT_RESET; option_enable = 1'b1;
    next_cycle(); option_enable = 1'b0;
    next_cycle(); keyboard_option = OPT_INTERVAL; option_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      option_enable = 1'b0;
      sample();
      tests++;
      if (food_switch !== 1'b0 || dut.sum !== 16'd0) begin
        fails++;
        $display("FAIL interval_zero cycle %0d: fs %b sum %0d want 0/0", i, food_switch, dut.sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pour();
    test_stop_mid_pour();
    test_async_reset();
    test_pour_sensor();
    test_interval();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
